regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter and scheduler for the 32-entry integer register file. Two writeback sources compete for the single register-file write port: the ALU result path and the memory-load path. Each source gets a one-entry holding buffer. The block grants the port to the older buffered write (round-robin on ties), discards writes to x0, and exports a pending-write mask for hazard detection. It sits between the execute/memory stages and the register file's `rd`/`wrd`/write-enable inputs.

## Interface
- `XLEN`, 32, data width of a register write
- `REG_AW`, 5, register address width (2**REG_AW registers)
- `clock` in 1: single clock; all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `alu_valid` in 1: ALU writeback request
- `alu_ready` out 1: ALU request accepted when `alu_valid && alu_ready` at a rising edge
- `alu_rd` in REG_AW: ALU destination register
- `alu_data` in XLEN: ALU result
- `mem_valid` in 1: load writeback request
- `mem_ready` out 1: load request accepted when `mem_valid && mem_ready`
- `mem_rd` in REG_AW: load destination register
- `mem_data` in XLEN: load data
- `rf_we` out 1: register-file write enable; the register file writes on the next edge
- `rf_waddr` out REG_AW: write address, maps to regfile `rd`
- `rf_wdata` out XLEN: write data, maps to regfile `wrd`
- `pend_mask` out 2**REG_AW: bit i=1 while a buffered write targets register i
- `fwd_rs` in REG_AW: forwarding lookup address (see Configuration)
- `fwd_hit` out 1: lookup matched a buffered write
- `fwd_data` out XLEN: forwarded data

## Operation
- State:
  - per source: `occ`, `rd`, `data`
  - `age`: 1 = ALU entry older than MEM entry
  - `rr`: round-robin pointer, 0 = ALU next on tie
- Accept:
  - `X_ready = !reset && (!occ_X || grant_X)`, so a draining entry accepts a new request in the same cycle.
  - An accepted request with rd≠0 loads the buffer and sets `occ`.
  - An accepted request with rd=0 is consumed and dropped: no buffer load, never appears on `rf_we`.
- Grant (combinational from registered state):
  - only ALU occupied → ALU
  - only MEM occupied → MEM
  - both occupied, loaded on different edges → the older entry
  - both loaded on the same edge → `rr`; `rr` then toggles to the other source
- Output:
  - `rf_we = occ_ALU || occ_MEM`; `rf_waddr`/`rf_wdata` come from the granted entry.
  - Both are 0 when nothing is occupied.
  - The granted entry clears on the edge, unless refilled by a same-edge accept.
- Ordering: two buffered writes to the same rd always commit oldest-first, so the register holds the younger value afterwards.
- `pend_mask`:
  - OR of one-hot(`rd`) over occupied entries; bit 0 is always 0.
  - Updates the cycle after accept and clears the cycle after commit.
- States per entry: EMPTY → FULL on accept (rd≠0); FULL → EMPTY on grant without accept; FULL → FULL on grant with same-edge accept.

## Timing
- Reset (synchronous): clears `occ`, `rd`, `data`, sets `age`=0 and `rr`=0.
  - During the reset cycle: `alu_ready`=`mem_ready`=0.
  - After reset: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `pend_mask`=0, `fwd_hit`=0, `fwd_data`=0; both readys =1 in the first cycle after.
- Latency: accept on edge k → `rf_we` high in cycle k..k+1 → register file written on edge k+1.
- Throughput: one write per cycle total. A single source streaming alone is never stalled.
- Contention: with both sources valid every cycle, each sees `ready`=1 on alternating cycles. Steady state is 1 commit per cycle.
- Reset mid-operation: buffered writes are discarded and never written. Requests presented in the reset cycle are not accepted.

## Configuration
- Macro `REGFILE_WB_FWD_EN`.
- Defined:
  - `fwd_hit`=1 when `fwd_rs`≠0 and an occupied entry has rd=`fwd_rs`.
  - `fwd_data` = that entry's data; if both entries match, the younger entry's data.
  - Combinational, 0 otherwise.
- Undefined: `fwd_hit` and `fwd_data` tied to 0, `fwd_rs` ignored; no lookup logic synthesized.

## Test plan
- Single ALU write: `alu_rd`=10, `alu_data`=0x46.
  - Next cycle: `rf_we`=1, `rf_waddr`=10, `rf_wdata`=0x46, `pend_mask`=0x400.
  - One cycle later: `rf_we`=0, `pend_mask`=0.
- x0 discard: `mem_rd`=0, `mem_data`=0x02007091 accepted → `rf_we` stays 0, `pend_mask` stays 0.
- Same-edge tie, different rd: ALU (rd=10, 0x46) and MEM (rd=11, 0x123a) accepted together after reset.
  - Commits in order: rd10 then rd11.
  - Repeat the tie → MEM commits first (`rr` toggled).
- Same-rd ordering: MEM rd=12=0x1111 accepted at edge k, ALU rd=12=0x2222 at edge k+1 while MEM is still held.
  - Commits: 0x1111 then 0x2222.
  - `pend_mask[12]`=1 throughout, clearing after the second commit.
- Reset mid-operation: both entries full, `reset` asserted one cycle.
  - No `rf_we` during or after reset.
  - All outputs 0; readys return to 1 the next cycle.
- With `REGFILE_WB_FWD_EN`: ALU rd=5=0xAAAA buffered, `fwd_rs`=5 → `fwd_hit`=1, `fwd_data`=0xAAAA.
  - `fwd_rs`=0 → `fwd_hit`=0.
  - Without the macro: `fwd_hit`=0 always.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Write-port arbiter for the 32-entry integer register file. Two writeback
// sources (ALU result, memory load) each own a one-entry holding buffer; the
// single register-file write port is granted to the older buffered write,
// with a round-robin pointer settling same-edge ties. Writes to x0 are
// accepted and dropped. A pending-write mask is exported for hazard checks.
//
// Optional feature: define REGFILE_WB_FWD_EN to enable the forwarding lookup
// (fwd_rs -> fwd_hit/fwd_data). Without it fwd_hit/fwd_data are tied to 0.
//
// Ports:
//   clock, reset                : single clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data : ALU writeback request handshake
//   mem_valid/mem_ready/mem_rd/mem_data : load writeback request handshake
//   rf_we/rf_waddr/rf_wdata     : register-file write port (written next edge)
//   pend_mask                   : bit i set while a buffered write targets xi
//   fwd_rs/fwd_hit/fwd_data     : forwarding lookup against buffered writes
module regfile_wb_arbiter #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [REG_AW-1:0]      alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [REG_AW-1:0]      mem_rd,
    input  logic [XLEN-1:0]        mem_data,
    output logic                   rf_we,
    output logic [REG_AW-1:0]      rf_waddr,
    output logic [XLEN-1:0]        rf_wdata,
    output logic [2**REG_AW-1:0]   pend_mask,
    input  logic [REG_AW-1:0]      fwd_rs,
    output logic                   fwd_hit,
    output logic [XLEN-1:0]        fwd_data
);

    localparam int NREG = 2**REG_AW;

    logic              alu_occ_q, alu_occ_d;
    logic [REG_AW-1:0] alu_rd_q, alu_rd_d;
    logic [XLEN-1:0]   alu_data_q, alu_data_d;
    logic              mem_occ_q, mem_occ_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic [XLEN-1:0]   mem_data_q, mem_data_d;
    // age: 1 = ALU entry older; tie: both entries were loaded on the same edge
    logic              age_q, age_d;
    logic              tie_q, tie_d;
    logic              rr_q, rr_d;

    logic              alu_older_s;
    logic              grant_alu_s;
    logic              grant_mem_s;
    logic              load_alu_s;
    logic              load_mem_s;

    // Arbitration, handshake and buffer-load decode from registered state
    always_comb begin
        alu_older_s = 1'b0;
        if (alu_occ_q && mem_occ_q) begin
            if (tie_q) begin
                alu_older_s = !rr_q;
            end else begin
                alu_older_s = age_q;
            end
        end else begin
            alu_older_s = alu_occ_q;
        end
        // No grant while in reset so nothing reaches the register file
        grant_alu_s = !reset && alu_occ_q && alu_older_s;
        grant_mem_s = !reset && mem_occ_q && !alu_older_s;
        // A draining entry can take a new request on the same edge
        alu_ready   = !reset && (!alu_occ_q || grant_alu_s);
        mem_ready   = !reset && (!mem_occ_q || grant_mem_s);
        // Accepted writes to x0 are consumed without loading a buffer
        load_alu_s  = alu_valid && alu_ready && (alu_rd != {REG_AW{1'b0}});
        load_mem_s  = mem_valid && mem_ready && (mem_rd != {REG_AW{1'b0}});
    end

    // Next-state for both holding buffers, age tracking and round-robin pointer
    always_comb begin
        alu_occ_d  = alu_occ_q;
        alu_rd_d   = alu_rd_q;
        alu_data_d = alu_data_q;
        mem_occ_d  = mem_occ_q;
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        age_d      = age_q;
        tie_d      = tie_q;

        if (load_alu_s) begin
            alu_occ_d  = 1'b1;
            alu_rd_d   = alu_rd;
            alu_data_d = alu_data;
        end else if (grant_alu_s) begin
            alu_occ_d  = 1'b0;
        end else begin
            alu_occ_d  = alu_occ_q;
        end

        if (load_mem_s) begin
            mem_occ_d  = 1'b1;
            mem_rd_d   = mem_rd;
            mem_data_d = mem_data;
        end else if (grant_mem_s) begin
            mem_occ_d  = 1'b0;
        end else begin
            mem_occ_d  = mem_occ_q;
        end

        // The entry loaded later is the younger one; a surviving entry is older
        if (load_alu_s && load_mem_s) begin
            tie_d = 1'b1;
        end else if (load_alu_s) begin
            tie_d = 1'b0;
            age_d = 1'b0;
        end else if (load_mem_s) begin
            tie_d = 1'b0;
            age_d = 1'b1;
        end else begin
            tie_d = tie_q;
            age_d = age_q;
        end

        // Each resolved tie hands the next tie to the other source
        rr_d = rr_q ^ (tie_q && alu_occ_q && mem_occ_q && !reset);
    end

    // Write-port and pending-mask outputs
    always_comb begin
        rf_we    = grant_alu_s || grant_mem_s;
        rf_waddr = {REG_AW{1'b0}};
        rf_wdata = {XLEN{1'b0}};
        if (grant_alu_s) begin
            rf_waddr = alu_rd_q;
            rf_wdata = alu_data_q;
        end else if (grant_mem_s) begin
            rf_waddr = mem_rd_q;
            rf_wdata = mem_data_q;
        end else begin
            rf_waddr = {REG_AW{1'b0}};
            rf_wdata = {XLEN{1'b0}};
        end

        pend_mask = {NREG{1'b0}};
        if (alu_occ_q) begin
            pend_mask[alu_rd_q] = 1'b1;
        end else begin
            pend_mask = pend_mask;
        end
        if (mem_occ_q) begin
            pend_mask[mem_rd_q] = 1'b1;
        end else begin
            pend_mask = pend_mask;
        end
        pend_mask[0] = 1'b0;
    end

`ifdef REGFILE_WB_FWD_EN
    logic alu_match_s;
    logic mem_match_s;

    // Forwarding lookup; on a double match the younger (non-older) entry wins
    always_comb begin
        alu_match_s = alu_occ_q && (alu_rd_q == fwd_rs) && (fwd_rs != {REG_AW{1'b0}});
        mem_match_s = mem_occ_q && (mem_rd_q == fwd_rs) && (fwd_rs != {REG_AW{1'b0}});
        fwd_hit     = alu_match_s || mem_match_s;
        fwd_data    = {XLEN{1'b0}};
        if (alu_match_s && mem_match_s) begin
            fwd_data = alu_older_s ? mem_data_q : alu_data_q;
        end else if (alu_match_s) begin
            fwd_data = alu_data_q;
        end else if (mem_match_s) begin
            fwd_data = mem_data_q;
        end else begin
            fwd_data = {XLEN{1'b0}};
        end
    end
`else
    logic unused_fwd_rs_s;
    assign unused_fwd_rs_s = ^fwd_rs;
    assign fwd_hit         = 1'b0;
    assign fwd_data        = {XLEN{1'b0}};
`endif

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_occ_q  <= 1'b0;
            alu_rd_q   <= {REG_AW{1'b0}};
            alu_data_q <= {XLEN{1'b0}};
            mem_occ_q  <= 1'b0;
            mem_rd_q   <= {REG_AW{1'b0}};
            mem_data_q <= {XLEN{1'b0}};
            age_q      <= 1'b0;
            tie_q      <= 1'b0;
            rr_q       <= 1'b0;
        end else begin
            alu_occ_q  <= alu_occ_d;
            alu_rd_q   <= alu_rd_d;
            alu_data_q <= alu_data_d;
            mem_occ_q  <= mem_occ_d;
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
            age_q      <= age_d;
            tie_q      <= tie_d;
            rr_q       <= rr_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [31:0] fwd_data;

`ifdef REGFILE_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    regfile_wb_arbiter #(.XLEN(32), .REG_AW(5)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pend_mask(pend_mask),
        .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: entries tagged with the edge number they were loaded on
    bit          m_init = 1'b0;
    bit          m_occ   [2];
    logic [4:0]  m_rd    [2];
    logic [31:0] m_data  [2];
    int          m_stamp [2];
    bit          m_rr = 1'b0;
    int          m_edge = 0;

    // Last sampled DUT outputs, for directed checks
    logic        o_we, o_ardy, o_mrdy, o_fhit;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata, o_pend, o_fdata;

    task automatic cyc(input bit rst, input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic [4:0] fr);
        int old, g, nm;
        bit rdy0, rdy1;
        logic        e_we, e_hit;
        logic [4:0]  e_addr;
        logic [31:0] e_data, e_pend, e_fdata;
        @(negedge clock);
        reset = rst; alu_valid = av; alu_rd = ar; alu_data = ad;
        mem_valid = mv; mem_rd = mr; mem_data = md; fwd_rs = fr;
        #1;
        old = -1;
        if (m_occ[0] && m_occ[1]) begin
            if (m_stamp[0] < m_stamp[1]) old = 0;
            else if (m_stamp[1] < m_stamp[0]) old = 1;
            else old = m_rr ? 1 : 0;
        end else if (m_occ[0]) old = 0;
        else if (m_occ[1]) old = 1;
        g = rst ? -1 : old;
        rdy0 = !rst && (!m_occ[0] || g == 0);
        rdy1 = !rst && (!m_occ[1] || g == 1);
        o_we = rf_we; o_waddr = rf_waddr; o_wdata = rf_wdata; o_pend = pend_mask;
        o_ardy = alu_ready; o_mrdy = mem_ready; o_fhit = fwd_hit; o_fdata = fwd_data;
        check("alu_ready", {31'd0, alu_ready}, {31'd0, rdy0});
        check("mem_ready", {31'd0, mem_ready}, {31'd0, rdy1});
        if (m_init) begin
            e_we   = (g >= 0);
            e_addr = (g == 0) ? m_rd[0] : (g == 1) ? m_rd[1] : 5'd0;
            e_data = (g == 0) ? m_data[0] : (g == 1) ? m_data[1] : 32'd0;
            e_pend = 32'd0;
            for (int i = 0; i < 2; i++) if (m_occ[i]) e_pend[m_rd[i]] = 1'b1;
            e_hit = 1'b0; e_fdata = 32'd0;
            if (FWD && fr != 5'd0) begin
                nm = 0;
                for (int i = 0; i < 2; i++) if (m_occ[i] && m_rd[i] == fr) nm++;
                if (nm == 2) begin
                    e_hit = 1'b1; e_fdata = m_data[1 - old];
                end else if (m_occ[0] && m_rd[0] == fr) begin
                    e_hit = 1'b1; e_fdata = m_data[0];
                end else if (m_occ[1] && m_rd[1] == fr) begin
                    e_hit = 1'b1; e_fdata = m_data[1];
                end
            end
            check("rf_we",     {31'd0, rf_we}, {31'd0, e_we});
            check("rf_waddr",  {27'd0, rf_waddr}, {27'd0, e_addr});
            check("rf_wdata",  rf_wdata, e_data);
            check("pend_mask", pend_mask, e_pend);
            check("fwd_hit",   {31'd0, fwd_hit}, {31'd0, e_hit});
            check("fwd_data",  fwd_data, e_fdata);
        end
        @(posedge clock);
        if (rst) begin
            m_init = 1'b1; m_occ[0] = 1'b0; m_occ[1] = 1'b0; m_rr = 1'b0;
        end else begin
            if (m_occ[0] && m_occ[1] && m_stamp[0] == m_stamp[1]) m_rr = !m_rr;
            if (g >= 0) m_occ[g] = 1'b0;
            if (av && rdy0 && ar != 5'd0) begin
                m_occ[0] = 1'b1; m_rd[0] = ar; m_data[0] = ad; m_stamp[0] = m_edge;
            end
            if (mv && rdy1 && mr != 5'd0) begin
                m_occ[1] = 1'b1; m_rd[1] = mr; m_data[1] = md; m_stamp[1] = m_edge;
            end
        end
        m_edge++;
    endtask

    task automatic idle(input logic [4:0] fr);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, fr);
    endtask

    initial begin
        m_occ[0] = 1'b0; m_occ[1] = 1'b0;
        reset = 1'b1; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0; fwd_rs = 5'd0;

        // Reset, then single ALU write
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
        cyc(1'b0, 1'b1, 5'd10, 32'h46, 1'b0, 5'd0, 32'd0, 5'd0);
        check("rst_we", {31'd0, o_we}, 32'd0);
        check("rst_pend", o_pend, 32'd0);
        check("rst_ardy", {31'd0, o_ardy}, 32'd1);
        check("rst_mrdy", {31'd0, o_mrdy}, 32'd1);
        check("rst_fhit", {31'd0, o_fhit}, 32'd0);
        idle(5'd0);
        check("alu_we", {31'd0, o_we}, 32'd1);
        check("alu_waddr", {27'd0, o_waddr}, 32'd10);
        check("alu_wdata", o_wdata, 32'h46);
        check("alu_pend", o_pend, 32'h400);
        idle(5'd0);
        check("alu_done_we", {31'd0, o_we}, 32'd0);
        check("alu_done_pend", o_pend, 32'd0);

        // x0 discard
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h02007091, 5'd0);
        idle(5'd0);
        check("x0_we", {31'd0, o_we}, 32'd0);
        check("x0_pend", o_pend, 32'd0);

        // Same-edge tie after reset, then repeated tie
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
        cyc(1'b0, 1'b1, 5'd10, 32'h46, 1'b1, 5'd11, 32'h123a, 5'd0);
        idle(5'd0);
        check("tie1_first", {27'd0, o_waddr}, 32'd10);
        check("tie1_pend", o_pend, 32'h0c00);
        idle(5'd0);
        check("tie1_second", {27'd0, o_waddr}, 32'd11);
        check("tie1_data", o_wdata, 32'h123a);
        cyc(1'b0, 1'b1, 5'd10, 32'h46, 1'b1, 5'd11, 32'h123a, 5'd0);
        idle(5'd0);
        check("tie2_first", {27'd0, o_waddr}, 32'd11);
        idle(5'd0);
        check("tie2_second", {27'd0, o_waddr}, 32'd10);

        // Same-rd ordering
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1111, 5'd0);
        cyc(1'b0, 1'b1, 5'd12, 32'h2222, 1'b0, 5'd0, 32'd0, 5'd0);
        check("ord_first", o_wdata, 32'h1111);
        check("ord_pend1", o_pend, 32'h1000);
        idle(5'd0);
        check("ord_second", o_wdata, 32'h2222);
        check("ord_pend2", o_pend, 32'h1000);
        idle(5'd0);
        check("ord_pend3", o_pend, 32'd0);

        // Reset mid-operation with both entries full
        cyc(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd0);
        cyc(1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 5'd0);
        check("mid_rst_we", {31'd0, o_we}, 32'd0);
        check("mid_rst_ardy", {31'd0, o_ardy}, 32'd0);
        check("mid_rst_mrdy", {31'd0, o_mrdy}, 32'd0);
        idle(5'd0);
        check("post_rst_we", {31'd0, o_we}, 32'd0);
        check("post_rst_pend", o_pend, 32'd0);
        check("post_rst_wdata", o_wdata, 32'd0);
        check("post_rst_ardy", {31'd0, o_ardy}, 32'd1);
        check("post_rst_mrdy", {31'd0, o_mrdy}, 32'd1);

        // Forwarding lookup
        cyc(1'b0, 1'b1, 5'd5, 32'hAAAA, 1'b0, 5'd0, 32'd0, 5'd5);
        cyc(1'b0, 1'b1, 5'd5, 32'hBBBB, 1'b0, 5'd0, 32'd0, 5'd5);
        check("fwd_hit5", {31'd0, o_fhit}, FWD ? 32'd1 : 32'd0);
        check("fwd_data5", o_fdata, FWD ? 32'hAAAA : 32'd0);
        idle(5'd0);
        check("fwd_hit0", {31'd0, o_fhit}, 32'd0);

        // Contention: both valid every cycle
        for (int i = 0; i < 12; i++)
            cyc(1'b0, 1'b1, 5'(i % 4 + 1), 32'(i), 1'b1, 5'(i % 3 + 1), 32'(i + 100), 5'(i % 4));

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
